// File: rtl/md_pkg.sv
// Shared packet layout and helpers for the force ring.
// Packet: {addr[8:0], null, fz, fy, fx}.
package md_pkg;

  localparam int PKT_W    = 106;
  localparam int NULL_BIT = 96;
  localparam int ADDR_W   = 9;
  localparam int CELL_W   = 8;
  localparam int FORCE_W  = 96;
  localparam int COMP_W   = 32;

  localparam logic [PKT_W-1:0] NULL_PACKET =
    {{ADDR_W{1'b0}}, 1'b1, {FORCE_W{1'b0}}};

  // Component-wise wrapping add of two {fz,fy,fx} triples.
  function automatic logic [FORCE_W-1:0] force_add(
    input logic [FORCE_W-1:0] a,
    input logic [FORCE_W-1:0] b
  );
    logic [FORCE_W-1:0] s;
    for (int i = 0; i < 3; i++) begin
      s[i*COMP_W +: COMP_W] =
        a[i*COMP_W +: COMP_W] + b[i*COMP_W +: COMP_W];
    end
    return s;
  endfunction

endpackage

// File: rtl/force_accumulator.sv
// Two-stage read-modify-write of the force BRAM.
// Forwards the in-flight and just-retired writes over stale reads.
module force_accumulator
  import md_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        offset,
  input  logic               in_valid,
  input  logic [ADDR_W-1:0]  in_addr,
  input  logic [FORCE_W-1:0] in_force,
  output logic [31:0]        bram_raddr,
  input  logic [FORCE_W-1:0] bram_rdata,
  output logic               bram_we,
  output logic [31:0]        bram_waddr,
  output logic [FORCE_W-1:0] bram_wdata,
  output logic [15:0]        acc_count,
  output logic               busy
);

  logic               a_valid_q, a_valid_d;
  logic [31:0]        a_addr_q, a_addr_d;
  logic [FORCE_W-1:0] a_force_q, a_force_d;

  logic               we_q, we_d;
  logic [31:0]        waddr_q, waddr_d;
  logic [FORCE_W-1:0] wdata_q, wdata_d;

  logic               old_we_q, old_we_d;
  logic [31:0]        old_waddr_q, old_waddr_d;
  logic [FORCE_W-1:0] old_wdata_q, old_wdata_d;

  logic [15:0]        cnt_q, cnt_d;
  logic [FORCE_W-1:0] operand;

  always_comb begin
    bram_raddr = '0;
    if (in_valid) begin
      bram_raddr = {{(32-ADDR_W){1'b0}}, in_addr} + offset;
    end
    a_valid_d = in_valid;
    a_addr_d  = bram_raddr;
    a_force_d = in_valid ? in_force : '0;

    // The retired write lost the read-first race; the live one is newer.
    operand = bram_rdata;
    if (old_we_q && old_waddr_q == a_addr_q) begin
      operand = old_wdata_q;
    end
    if (we_q && waddr_q == a_addr_q) begin
      operand = wdata_q;
    end

    we_d    = a_valid_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (a_valid_q) begin
      waddr_d = a_addr_q;
      wdata_d = force_add(operand, a_force_q);
    end

    old_we_d    = we_q;
    old_waddr_d = waddr_q;
    old_wdata_d = wdata_q;

    cnt_d = cnt_q + {15'd0, a_valid_q};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_valid_q   <= 1'b0;
      a_addr_q    <= '0;
      a_force_q   <= '0;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      old_we_q    <= 1'b0;
      old_waddr_q <= '0;
      old_wdata_q <= '0;
      cnt_q       <= '0;
    end else begin
      a_valid_q   <= a_valid_d;
      a_addr_q    <= a_addr_d;
      a_force_q   <= a_force_d;
      we_q        <= we_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      old_we_q    <= old_we_d;
      old_waddr_q <= old_waddr_d;
      old_wdata_q <= old_wdata_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bram_we    = we_q;
  assign bram_waddr = waddr_q;
  assign bram_wdata = wdata_q;
  assign acc_count  = cnt_q;
  assign busy       = a_valid_q;

endmodule

// File: rtl/force_ring_node.sv
// Force ring node: forwards foreign packets, injects local ones,
// and accumulates packets owned by this cell into the force BRAM.
module force_ring_node
  import md_pkg::*;
#(
  parameter int DBSIZE = 256
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         Cell,
  input  logic                double_buffer,
  input  logic [PKT_W-1:0]    prev,
  input  logic [CELL_W-1:0]   prev_cell,
  input  logic [PKT_W-1:0]    pipe_in,
  input  logic [CELL_W-1:0]   pipe_cell,
  input  logic                pipe_valid,
  output logic                pipe_ready,
  output logic [PKT_W-1:0]    next,
  output logic [CELL_W-1:0]   next_cell,
  output logic [31:0]         bram_raddr,
  input  logic [FORCE_W-1:0]  bram_rdata,
  output logic                bram_we,
  output logic [31:0]         bram_waddr,
  output logic [FORCE_W-1:0]  bram_wdata,
  output logic                in_flight,
  output logic [15:0]         acc_count
);

  logic [CELL_W-1:0] own_cell;
  logic              prev_live;
  logic              own_ring;
  logic              pass_ring;
  logic              pipe_take;
  logic              pipe_own;
  logic              cons_valid;
  logic [PKT_W-1:0]  cons_pkt;
  logic [31:0]       offset;
  logic              acc_busy;

  logic [PKT_W-1:0]  next_q, next_d;
  logic [CELL_W-1:0] next_cell_q, next_cell_d;

  logic unused_cell_hi;
  assign unused_cell_hi = ^Cell[31:CELL_W];

  always_comb begin
    own_cell   = Cell[CELL_W-1:0];
    prev_live  = !prev[NULL_BIT];
    own_ring   = prev_live && (prev_cell == own_cell);
    pass_ring  = prev_live && (prev_cell != own_cell);
    pipe_ready = !own_ring && !pass_ring;
    pipe_take  = pipe_valid && pipe_ready;
    pipe_own   = pipe_take && (pipe_cell == own_cell);
    cons_valid = own_ring || pipe_own;
    cons_pkt   = own_ring ? prev : pipe_in;
    offset     = double_buffer ? 32'(DBSIZE) : 32'd0;

    next_d      = NULL_PACKET;
    next_cell_d = '0;
    if (pass_ring) begin
      next_d      = prev;
      next_cell_d = prev_cell;
    end else if (pipe_take && !pipe_own) begin
      next_d      = pipe_in;
      next_cell_d = pipe_cell;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      next_q      <= NULL_PACKET;
      next_cell_q <= '0;
    end else begin
      next_q      <= next_d;
      next_cell_q <= next_cell_d;
    end
  end

  force_accumulator u_acc (
    .clk        (clk),
    .reset      (reset),
    .offset     (offset),
    .in_valid   (cons_valid),
    .in_addr    (cons_pkt[PKT_W-1 -: ADDR_W]),
    .in_force   (cons_pkt[FORCE_W-1:0]),
    .bram_raddr (bram_raddr),
    .bram_rdata (bram_rdata),
    .bram_we    (bram_we),
    .bram_waddr (bram_waddr),
    .bram_wdata (bram_wdata),
    .acc_count  (acc_count),
    .busy       (acc_busy)
  );

  assign next      = next_q;
  assign next_cell = next_cell_q;
  assign in_flight = !next_q[NULL_BIT] || acc_busy;

endmodule
